// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : Shared encodings and helpers for the MIPS multiply/divide unit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    // Widest value the helpers operate on: the full 2*WIDTH product for WIDTH<=32
    localparam int MDU_MAX_W = 64;

    // Operation encodings as driven by the control unit
    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    // FSM state encodings
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    // LO value written on a divide by zero (sliced down to WIDTH by the user)
    localparam logic [MDU_MAX_W-1:0] DIV0_LO = '1;

    // Two's-complement negate when en is set; truncating the result to a
    // narrower width gives the correct negation at that width as well.
    function automatic logic [MDU_MAX_W-1:0] cond_neg(input logic [MDU_MAX_W-1:0] v,
                                                      input logic en);
        return en ? (~v + MDU_MAX_W'(1)) : v;
    endfunction

    // Magnitude of a value whose sign bit is supplied separately; unsigned
    // operands pass sign=0 and come back unchanged.
    function automatic logic [MDU_MAX_W-1:0] abs_val(input logic [MDU_MAX_W-1:0] v,
                                                     input logic sign);
        return cond_neg(v, sign);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative radix-2 MULT/MULTU/DIV/DIVU unit holding HI/LO.
//               Fixed latency of WIDTH+1 cycles after the accept edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,   // must be <= MDU_MAX_W/2
    parameter int CNT_W = 6     // 2**CNT_W > WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    // Multiply: {partial high, remaining multiplier}; divide: {remainder, quotient}
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   opd;        // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]   a_orig;     // original dividend, returned in HI on divide by zero
    logic               is_div;
    logic               neg_q;      // negate product / quotient
    logic               neg_r;      // negate remainder
    logic               b_zero;

    logic               sign_op;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   quo_res;
    logic [WIDTH-1:0]   rem_res;

    assign busy = (state != S_IDLE);

    // Operand magnitudes, one radix-2 step for either operation, and sign fix-up
    always_comb begin
        sign_op   = ~op[0];
        sa        = sign_op & a[WIDTH-1];
        sb        = sign_op & b[WIDTH-1];
        abs_a     = WIDTH'(abs_val(MDU_MAX_W'(a), sa));
        abs_b     = WIDTH'(abs_val(MDU_MAX_W'(b), sb));

        // Shift-add: add multiplicand into the high half when the current
        // multiplier bit is set, then shift the whole product right by one.
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opd} : '0);

        // Restoring divide: shift the next dividend bit into the remainder and
        // subtract the divisor only when it fits.
        div_shift = prod[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, opd});
        div_diff  = div_shift[WIDTH-1:0] - opd;

        if (is_div) begin
            step_next = div_ge ? {div_diff, prod[WIDTH-2:0], 1'b1}
                               : {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
        end else begin
            step_next = {mul_sum, prod[WIDTH-1:1]};
        end

        mul_res   = (2*WIDTH)'(cond_neg(MDU_MAX_W'(prod), neg_q));
        quo_res   = WIDTH'(cond_neg(MDU_MAX_W'(prod[WIDTH-1:0]), neg_q));
        rem_res   = WIDTH'(cond_neg(MDU_MAX_W'(prod[2*WIDTH-1:WIDTH]), neg_r));
    end

    // Control FSM, iteration datapath and the architectural HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            prod     <= '0;
            opd      <= '0;
            a_orig   <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            b_zero   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Multiply iterates over the multiplier in the low half;
                        // divide iterates over the dividend in the low half.
                        is_div <= op[1];
                        prod   <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                        opd    <= op[1] ? abs_b : abs_a;
                        a_orig <= a;
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        b_zero <= (b == '0);
                        cnt    <= '0;
                        state  <= S_CALC;
                    end else begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                end
                S_CALC: begin
                    prod <= step_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!is_div) begin
                        hi <= mul_res[2*WIDTH-1:WIDTH];
                        lo <= mul_res[WIDTH-1:0];
                    end else if (b_zero) begin
                        hi       <= a_orig;
                        lo       <= DIV0_LO[WIDTH-1:0];
                        div_zero <= 1'b1;
                    end else begin
                        hi <= rem_res;
                        lo <= quo_res;
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the single-cycle MIPS core. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers.
- Sits beside the ALU and is fed by the register-file read ports (rs, rt). The control unit decodes funct and drives start/op.
- Asserts busy so the PC can stall; MFHI/MFLO read hi/lo through the write-back mux.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  launch operation; sampled only when busy=0.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- mthi  input  1  write a into HI.
- mtlo  input  1  write a into LO.
- busy  output  1  operation in progress; core stalls PC while high.
- done  output  1  one-cycle pulse when hi/lo take a new result.
- div_zero  output  1  valid with done; divisor was zero.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, active-high): state=IDLE; hi, lo, busy, done, div_zero, counter and internal accumulators all 0. Reset mid-operation aborts the operation, and the result is never written.
- States:
  - IDLE: if start, latch |a|, |b| (signed ops) or a, b (unsigned ops); latch result signs; counter=0; go to CALC.
  - CALC: one radix-2 step per cycle; counter increments; after WIDTH steps go to FIX.
  - FIX: apply sign correction; write hi/lo; done=1 (div_zero if applicable); go to IDLE.
- Latency: start accepted at edge E0. busy=1 from E0 through E32 (WIDTH=32). hi/lo/done update at E33, busy=0 after E33. Latency is the same for all four ops.
- Multiply: shift-add over a 2*WIDTH product. The signed result is negated in FIX when sign(a)^sign(b). {hi,lo} = full 64-bit product.
- Divide: restoring algorithm.
  - lo = quotient, hi = remainder.
  - Signed: quotient negative iff sign(a)^sign(b); remainder takes the sign of a (truncating division).
  - 0x80000000 / 0xFFFFFFFF signed -> lo=0x80000000, hi=0. No trap.
- Divide by zero: the iteration still runs the full latency. Result hi=a (original dividend), lo=all ones, div_zero=1 for the done cycle. Same for signed and unsigned.
- done and div_zero are high exactly one cycle and otherwise 0.
- mthi/mtlo: honoured only in IDLE with start=0; take effect at the next edge. Both may be asserted together.
- Simultaneous events and ignored inputs:
  - start with mthi/mtlo in IDLE: start wins, the moves are dropped.
  - start while busy: ignored, not queued.
  - mthi/mtlo while busy: ignored.
- hi/lo hold their previous values throughout CALC. Intermediate values are never visible.
- Operand inputs may change after the accept edge without effect.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11.
  - state encodings S_IDLE, S_CALC, S_FIX.
  - DIV0_LO constant (all ones).
- No sub-module. The single FSM plus datapath fits in one module. The abs/negate helpers are functions in the package.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulse 1 cycle, busy high 33 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
- DIVU a=100, b=0 -> hi=0x64, lo=0xFFFFFFFF, div_zero=1 with done, then 0 next cycle.
- MTHI a=0x1234 then MTLO a=0x5678 in IDLE -> hi=0x1234, lo=0x5678. mthi, or a second start, issued at cycle 10 of a MULT -> ignored, MULT result intact.
- Assert reset at cycle 15 of a DIV -> immediately busy=0, hi=lo=0, no done. Deassert, then start MULTU 6*7 -> lo=42, hi=0.
